// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : alu_pkg
// Purpose : Opcode/state types and helpers shared by the sequential ALU.
// Rev     : 1.0  initial release
// ============================================================================
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SHL  = 3'b001,
        OP_SHR  = 3'b010,
        OP_XOR  = 3'b011,
        OP_AND  = 3'b100,
        OP_ROL  = 3'b101,
        OP_SUB  = 3'b110,
        OP_PASS = 3'b111
    } alu_op_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    function automatic logic is_shift(input alu_op_t op);
        return (op == OP_SHL) || (op == OP_SHR) || (op == OP_ROL);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_step.sv
`default_nettype none
// ============================================================================
// Module  : alu_step
// Purpose : Combinational ALU core: single-cycle ops and one-bit shift steps.
// Rev     : 1.0  initial release
// ============================================================================
module alu_step
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  alu_op_t          op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             carry_en
);

    logic [WIDTH:0] sum;

    always_comb begin
        result   = a;
        carry    = 1'b0;
        carry_en = 1'b0;
        sum      = '0;
        case (op)
            OP_ADD: begin
                sum      = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
                result   = sum[WIDTH-1:0];
                carry    = sum[WIDTH];
                carry_en = 1'b1;
            end
            OP_SUB: begin
                // carry out of A + ~B + cin is the inverted borrow
                sum      = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, cin};
                result   = sum[WIDTH-1:0];
                carry    = sum[WIDTH];
                carry_en = 1'b1;
            end
            OP_SHL: begin
                result   = {a[WIDTH-2:0], cin};
                carry    = a[WIDTH-1];
                carry_en = 1'b1;
            end
            OP_SHR: begin
                result   = {cin, a[WIDTH-1:1]};
                carry    = a[0];
                carry_en = 1'b1;
            end
            OP_ROL:  result = {a[WIDTH-2:0], a[WIDTH-1]};
            OP_XOR:  result = a ^ b;
            OP_AND:  result = a & b;
            OP_PASS: result = a;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module  : alu_seq
// Purpose : Sequential ALU with registered result/flags, persistent carry and
//           bit-serial shifts/rotates behind a valid/ready handshake.
// Rev     : 1.0  initial release
// ============================================================================
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       alu_cmd,
    input  logic             cin_sel,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    output logic             out_valid,
    output logic [WIDTH-1:0] rslt,
    output logic             sc_o,
    output logic             zero,
    output logic             pari
);

    state_t               state;
    logic [SHAMT_W-1:0]   cnt;
    logic [WIDTH-1:0]     work;
    alu_op_t              op_q;
    logic                 csel_q;
    logic                 cf;

    alu_op_t              cmd;
    logic [SHAMT_W-1:0]   amt;
    logic                 busy;
    logic                 accept;
    alu_op_t              step_op;
    logic [WIDTH-1:0]     step_a;
    logic                 step_csel;
    logic                 step_cin;
    logic [WIDTH-1:0]     step_res;
    logic                 step_carry;
    logic                 step_carry_en;
    logic [WIDTH-1:0]     fin_val;

    assign cmd    = alu_op_t'(alu_cmd);
    assign amt    = inB[SHAMT_W-1:0];
    assign busy   = (state == SHIFT);
    assign accept = in_valid && in_ready;
    assign sc_o   = cf;

    // The step unit sees the live inputs when idle and the work register while shifting
    assign step_op   = busy ? op_q   : cmd;
    assign step_a    = busy ? work   : inA;
    assign step_csel = busy ? csel_q : cin_sel;
    assign step_cin  = step_csel ? cf : (step_op == OP_SUB);

    alu_step #(.WIDTH(WIDTH)) u_step (
        .op       (step_op),
        .a        (step_a),
        .b        (inB),
        .cin      (step_cin),
        .result   (step_res),
        .carry    (step_carry),
        .carry_en (step_carry_en)
    );

    // A zero-amount shift/rotate passes A through unchanged
    assign fin_val = (!busy && is_shift(cmd)) ? inA : step_res;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            rslt      <= '0;
            zero      <= 1'b1;
            pari      <= 1'b0;
            cf        <= 1'b0;
            cnt       <= '0;
            work      <= '0;
            op_q      <= OP_ADD;
            csel_q    <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (is_shift(cmd) && (amt != '0)) begin
                            work     <= inA;
                            cnt      <= amt;
                            op_q     <= cmd;
                            csel_q   <= cin_sel;
                            state    <= SHIFT;
                            in_ready <= 1'b0;
                        end else begin
                            rslt      <= fin_val;
                            zero      <= (fin_val == '0);
                            pari      <= ^fin_val;
                            out_valid <= 1'b1;
                            if (step_carry_en && !is_shift(cmd))
                                cf <= step_carry;
                        end
                    end
                end
                SHIFT: begin
                    work <= step_res;
                    cnt  <= cnt - 1'b1;
                    if (step_carry_en)
                        cf <= step_carry;
                    if (cnt == SHAMT_W'(1)) begin
                        rslt      <= step_res;
                        zero      <= (step_res == '0);
                        pari      <= ^step_res;
                        out_valid <= 1'b1;
                        state     <= IDLE;
                        in_ready  <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_alu_seq
// Purpose : Self-checking bench for alu_seq (WIDTH = 8) against a
//           transaction-level reference model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_alu_seq;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] alu_cmd = 3'b000;
    logic       cin_sel = 1'b0;
    logic [7:0] inA = 8'h00;
    logic [7:0] inB = 8'h00;
    logic       out_valid;
    logic [7:0] rslt;
    logic       sc_o;
    logic       zero;
    logic       pari;

    alu_seq #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_cmd   (alu_cmd),
        .cin_sel   (cin_sel),
        .inA       (inA),
        .inB       (inB),
        .out_valid (out_valid),
        .rslt      (rslt),
        .sc_o      (sc_o),
        .zero      (zero),
        .pari      (pari)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic       m_busy = 1'b0;
    int         m_k = 0;
    int         m_n = 0;
    logic [2:0] s_op = 3'b000;
    logic [7:0] s_a = 8'h00;
    logic       s_cf0 = 1'b0;
    logic       s_csel = 1'b0;
    logic       m_cf = 1'b0;
    logic [7:0] m_rslt = 8'h00;
    logic       m_ov = 1'b0;
    logic       m_acc = 1'b0;

    function automatic logic [8:0] rotl9(input logic [8:0] x, input int k);
        logic [17:0] t;
        t = {x, x} << k;
        return t[17:9];
    endfunction

    function automatic logic [8:0] rotr9(input logic [8:0] x, input int k);
        logic [17:0] t;
        t = {x, x} >> k;
        return t[8:0];
    endfunction

    // {cf, result} after k shift steps, as a whole-word view of the operation
    function automatic logic [8:0] shift_state(input logic [2:0] op, input logic [7:0] a,
                                               input logic cf0, input logic csel, input int k);
        logic [8:0]  v;
        logic [15:0] t;
        case (op)
            OP_SHL: begin
                v = {cf0, a};
                v = csel ? rotl9(v, k) : (v << k);
                return v;
            end
            OP_SHR: begin
                v = {a, cf0};
                v = csel ? rotr9(v, k) : (v >> k);
                return {v[0], v[8:1]};
            end
            default: begin
                t = {a, a} << k;
                return {cf0, t[15:8]};
            end
        endcase
    endfunction

    task automatic model_reset();
        m_busy = 1'b0; m_k = 0; m_n = 0;
        m_cf = 1'b0; m_rslt = 8'h00; m_ov = 1'b0; m_acc = 1'b0;
    endtask

    task automatic model_edge();
        logic [8:0] v;
        int         s;
        m_ov  = 1'b0;
        m_acc = 1'b0;
        if (m_busy) begin
            m_k++;
            v = shift_state(s_op, s_a, s_cf0, s_csel, m_k);
            m_cf = v[8];
            if (m_k == m_n) begin
                m_rslt = v[7:0];
                m_busy = 1'b0;
                m_ov   = 1'b1;
            end
        end else if (in_valid) begin
            m_acc = 1'b1;
            case (alu_cmd)
                OP_SHL, OP_SHR, OP_ROL: begin
                    if (inB[2:0] == 3'd0) begin
                        m_rslt = inA;
                        m_ov   = 1'b1;
                    end else begin
                        s_op = alu_cmd; s_a = inA; s_cf0 = m_cf; s_csel = cin_sel;
                        m_n = int'(inB[2:0]); m_k = 0; m_busy = 1'b1;
                    end
                end
                OP_ADD: begin
                    s = int'(inA) + int'(inB) + ((cin_sel && m_cf) ? 1 : 0);
                    m_rslt = s[7:0]; m_cf = s[8]; m_ov = 1'b1;
                end
                OP_SUB: begin
                    s = int'(inA) + (255 - int'(inB)) + (cin_sel ? (m_cf ? 1 : 0) : 1);
                    m_rslt = s[7:0]; m_cf = s[8]; m_ov = 1'b1;
                end
                OP_XOR:  begin m_rslt = inA ^ inB; m_ov = 1'b1; end
                OP_AND:  begin m_rslt = inA & inB; m_ov = 1'b1; end
                default: begin m_rslt = inA;       m_ov = 1'b1; end
            endcase
        end
    endtask

    // Compare process: model steps on every edge, outputs checked 1 ns later
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_edge();
        #1;
        check("in_ready",  in_ready,  !m_busy);
        check("out_valid", out_valid, m_ov);
        check("rslt",      rslt,      m_rslt);
        check("sc_o",      sc_o,      m_cf);
        check("zero",      zero,      m_rslt == 8'h00);
        check("pari",      pari,      ^m_rslt);
    end

    // ---------------- directed helpers ----------------
    task automatic do_op(input logic [2:0] cmd, input logic csel, input logic [7:0] a,
                         input logic [7:0] b, output int lat);
        int tries;
        alu_cmd = cmd; cin_sel = csel; inA = a; inB = b; in_valid = 1'b1;
        tries = 0;
        lat = -1;
        forever begin
            @(posedge clk); #2;
            if (m_acc) break;
            tries++;
            if (tries > 40) begin
                check("accept_timeout", 0, 1);
                @(negedge clk); in_valid = 1'b0;
                return;
            end
        end
        lat = 0;
        while (!m_ov) begin
            @(negedge clk); in_valid = 1'b0;
            @(posedge clk); #2;
            lat++;
            if (lat > 40) begin
                check("done_timeout", 0, 1);
                break;
            end
        end
        @(negedge clk); in_valid = 1'b0;
    endtask

    initial begin
        int lat;
        int cnt;
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int cnt;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // ADD carry chain
        do_op(OP_ADD, 1'b0, 8'hFF, 8'h01, lat);
        check("add1_lat", lat, 0);
        check("add1_rslt", rslt, 8'h00);
        check("add1_cf", sc_o, 1'b1);
        check("add1_zero", zero, 1'b1);
        do_op(OP_ADD, 1'b1, 8'h10, 8'h20, lat);
        check("add2_rslt", rslt, 8'h31);
        check("add2_cf", sc_o, 1'b0);

        // SUB borrow
        do_op(OP_SUB, 1'b0, 8'h05, 8'h07, lat);
        check("sub1_rslt", rslt, 8'hFE);
        check("sub1_cf", sc_o, 1'b0);
        check("sub1_pari", pari, 1'b1);
        do_op(OP_SUB, 1'b0, 8'h07, 8'h05, lat);
        check("sub2_rslt", rslt, 8'h02);
        check("sub2_cf", sc_o, 1'b1);

        // Multi-cycle shifts
        do_op(OP_SHL, 1'b0, 8'h81, 8'h03, lat);
        check("shl3_lat", lat, 3);
        check("shl3_rslt", rslt, 8'h08);
        check("shl3_cf", sc_o, 1'b0);
        do_op(OP_SHR, 1'b0, 8'h81, 8'h01, lat);
        check("shr1_lat", lat, 1);
        check("shr1_rslt", rslt, 8'h40);
        check("shr1_cf", sc_o, 1'b1);

        // Rotate and amount 0
        do_op(OP_ROL, 1'b0, 8'h81, 8'h04, lat);
        check("rol4_lat", lat, 4);
        check("rol4_rslt", rslt, 8'h18);
        check("rol4_cf", sc_o, 1'b1);
        do_op(OP_ROL, 1'b0, 8'h81, 8'h00, lat);
        check("rol0_lat", lat, 0);
        check("rol0_rslt", rslt, 8'h81);

        // Back-to-back with in_valid held
        alu_cmd = OP_XOR; cin_sel = 1'b0; inA = 8'hF0; inB = 8'h3C; in_valid = 1'b1;
        @(posedge clk); #2;
        check("b2b_xor_ov", out_valid, 1'b1);
        check("b2b_xor_rslt", rslt, 8'hCC);
        @(negedge clk); alu_cmd = OP_AND;
        @(posedge clk); #2;
        check("b2b_and_ov", out_valid, 1'b1);
        check("b2b_and_rslt", rslt, 8'h30);
        @(negedge clk); in_valid = 1'b0;

        // Request held during SHIFT is taken only once in_ready returns
        alu_cmd = OP_SHL; inA = 8'h81; inB = 8'h03; in_valid = 1'b1;
        @(posedge clk); #2;
        @(negedge clk); alu_cmd = OP_PASS; inA = 8'h5A;
        cnt = 0;
        do begin
            @(posedge clk); #2;
            cnt++;
        end while (!m_acc && cnt < 40);
        check("hold_accept_edges", cnt, 4);
        @(negedge clk); in_valid = 1'b0;
        check("hold_pass_rslt", rslt, 8'h5A);

        // Reset in the middle of SHL by 5
        do_op(OP_ADD, 1'b0, 8'h80, 8'h80, lat);
        do_op(OP_PASS, 1'b0, 8'h5A, 8'h00, lat);
        alu_cmd = OP_SHL; inA = 8'h81; inB = 8'h05; in_valid = 1'b1;
        @(posedge clk); #2;
        @(negedge clk); in_valid = 1'b0;
        @(posedge clk); @(posedge clk); #2;
        rst_n = 1'b0;
        #2;
        check("rst_rslt", rslt, 8'h00);
        check("rst_zero", zero, 1'b1);
        check("rst_cf", sc_o, 1'b0);
        check("rst_ready", in_ready, 1'b1);
        check("rst_ov", out_valid, 1'b0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        repeat (8) begin
            @(posedge clk); #2;
            if (out_valid) cnt++;
        end
        check("rst_no_ov", cnt, 0);
        @(negedge clk);

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            alu_cmd  = 3'($urandom_range(0, 7));
            cin_sel  = 1'($urandom_range(0, 1));
            inA      = 8'($urandom_range(0, 255));
            inB      = 8'($urandom_range(0, 255));
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (10) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
